// File: rtl/joker_pkg.sv
// ---------------------------------------------------------------------------
// joker_pkg
// Shared definitions for the front-end control block.
//   - reset_ctrl bit indices (a '1' in any bit means disabled / held in reset)
//   - group masks used by the power sequencer stages
//   - sequencer state enumeration
//   - rc_release(): applies one sequencer stage to the applied-state vector
// ---------------------------------------------------------------------------
package joker_pkg;

  localparam int unsigned RC_W = 8;

  // reset_ctrl bit indices
  localparam int unsigned RC_GATE  = 7;
  localparam int unsigned RC_CIPWR = 6;
  localparam int unsigned RC_ANT   = 5;
  localparam int unsigned RC_SPARE = 4;
  localparam int unsigned RC_DTMB  = 3;
  localparam int unsigned RC_ATSC  = 2;
  localparam int unsigned RC_TU    = 1;
  localparam int unsigned RC_DVB   = 0;

  // Stage groups: power rails (incl. spare), demod resets, tuner reset, I2C gate
  localparam logic [RC_W-1:0] RC_PWR_MASK  =
    RC_W'((32'd1 << RC_CIPWR) | (32'd1 << RC_ANT) | (32'd1 << RC_SPARE));
  localparam logic [RC_W-1:0] RC_DEM_MASK  =
    RC_W'((32'd1 << RC_DTMB) | (32'd1 << RC_ATSC) | (32'd1 << RC_DVB));
  localparam logic [RC_W-1:0] RC_TU_MASK   = RC_W'(32'd1 << RC_TU);
  localparam logic [RC_W-1:0] RC_GATE_MASK = RC_W'(32'd1 << RC_GATE);

  // Only the real rails need a settle wait; the spare bit is released silently
  localparam logic [RC_W-1:0] RC_RAIL_MASK =
    RC_W'((32'd1 << RC_CIPWR) | (32'd1 << RC_ANT));

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_PWR      = 3'd1,
    SEQ_PWR_WAIT = 3'd2,
    SEQ_TU_REL   = 3'd3,
    SEQ_TU_WAIT  = 3'd4,
    SEQ_DEM_REL  = 3'd5,
    SEQ_DEM_WAIT = 3'd6,
    SEQ_GATE     = 3'd7
  } seq_state_e;

  // Clear the bits of 'mask' that the latched target wants enabled. Bits the
  // live request currently wants disabled stay set: disables always win.
  function automatic logic [RC_W-1:0] rc_release(
    input logic [RC_W-1:0] act,
    input logic [RC_W-1:0] tgt,
    input logic [RC_W-1:0] eff,
    input logic [RC_W-1:0] mask
  );
    return (act & ~(mask & ~tgt)) | eff;
  endfunction

endpackage

// File: rtl/oc_filter.sv
// ---------------------------------------------------------------------------
// oc_filter
// Overcurrent qualification for one rail: 2-flop synchronizer, glitch filter
// counter and sticky fault flag with qualified clear.
//   clk      in  sequencer clock
//   reset    in  asynchronous, active-high
//   oc_n     in  raw overcurrent pin, asynchronous, active-low
//   rail_on  in  rail currently enabled; the filter only counts while on
//   clr      in  single-cycle clear request, honoured only if the pin is high
//   fault    out sticky fault flag (registered)
// ---------------------------------------------------------------------------
module oc_filter #(
  parameter int unsigned OC_FILTER_CYC = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic oc_n,
  input  logic rail_on,
  input  logic clr,
  output logic fault
);

  localparam int unsigned CNT_W = $clog2(OC_FILTER_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OC_FILTER_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OC_FILTER_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             qual_c;
  logic             set_c;

  // Filter counter, fault set/clear; set has priority over clear
  always_comb begin
    sync1_d = oc_n;
    sync2_d = sync1_q;
    cnt_d   = '0;
    fault_d = fault_q;
    qual_c  = ~sync2_q & rail_on;
    set_c   = 1'b0;

    if (qual_c) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      set_c = (cnt_q >= CNT_LAST);
    end

    if (set_c) begin
      fault_d = 1'b1;
    end else if (clr && sync2_q) begin
      fault_d = 1'b0;
    end
  end

  // Synchronizer resets to the idle (high) pin level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;

endmodule

// File: rtl/fe_power_sequencer.sv
// ---------------------------------------------------------------------------
// fe_power_sequencer
// Timed power/reset sequencer between the host reset_ctrl register and the
// front-end board pins. Disables are applied on the next edge in any state;
// enables are staged rails -> tuner reset -> demod resets -> I2C gate, with
// settle waits after rail and reset-release stages. Suspend and sticky
// overcurrent faults force the affected bits to disabled.
//   clk                in  usb_ulpi_clk domain
//   reset              in  asynchronous, active-high
//   req_ctrl[7:0]      in  requested state ('1' = disabled / in reset)
//   suspend            in  forces every bit disabled
//   ci_overcurrent_n   in  CI rail overcurrent pin, async, active-low
//   tps_overcurrent_n  in  antenna rail overcurrent pin, async, active-low
//   fault_clr          in  single-cycle fault clear pulse
//   act_ctrl[7:0]      out applied state, same bit map
//   busy               out enable sequence in progress
//   oc_fault[1:0]      out sticky faults: [0] CI, [1] antenna
// ---------------------------------------------------------------------------
module fe_power_sequencer
  import joker_pkg::*;
#(
  parameter int unsigned PWR_SETTLE_CYC = 600000,
  parameter int unsigned RST_HOLD_CYC   = 6000,
  parameter int unsigned OC_FILTER_CYC  = 60
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RC_W-1:0] req_ctrl,
  input  logic            suspend,
  input  logic            ci_overcurrent_n,
  input  logic            tps_overcurrent_n,
  input  logic            fault_clr,
  output logic [RC_W-1:0] act_ctrl,
  output logic            busy,
  output logic [1:0]      oc_fault
);

  localparam int unsigned MAX_CYC  = (PWR_SETTLE_CYC > RST_HOLD_CYC) ?
                                     PWR_SETTLE_CYC : RST_HOLD_CYC;
  localparam int unsigned CNT_W    = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(PWR_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_HOLD_CYC - 1);

  seq_state_e      state_q, state_d;
  logic [RC_W-1:0] act_q, act_d;
  logic [RC_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [1:0]      fault_w;
  logic [RC_W-1:0] eff_c;
  logic [RC_W-1:0] rel_c;
  logic            rising_c;
  logic            cnt_done_c;

  // Overcurrent filters; a rail only counts as "on" while its act bit is 0
  oc_filter #(
    .OC_FILTER_CYC (OC_FILTER_CYC)
  ) u_oc_ci (
    .clk     (clk),
    .reset   (reset),
    .oc_n    (ci_overcurrent_n),
    .rail_on (~act_q[RC_CIPWR]),
    .clr     (fault_clr),
    .fault   (fault_w[0])
  );

  oc_filter #(
    .OC_FILTER_CYC (OC_FILTER_CYC)
  ) u_oc_ant (
    .clk     (clk),
    .reset   (reset),
    .oc_n    (tps_overcurrent_n),
    .rail_on (~act_q[RC_ANT]),
    .clr     (fault_clr),
    .fault   (fault_w[1])
  );

  // Effective target: suspend, then sticky faults override the host request
  always_comb begin
    eff_c = suspend ? {RC_W{1'b1}} : req_ctrl;
    if (fault_w[0]) eff_c[RC_CIPWR] = 1'b1;
    if (fault_w[1]) eff_c[RC_ANT]   = 1'b1;
  end

  // Sequencer next-state and applied-state logic
  always_comb begin
    state_d    = state_q;
    act_d      = act_q | eff_c;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    rel_c      = '0;
    rising_c   = |(eff_c & ~act_q);
    cnt_done_c = (cnt_q == '0);

    unique case (state_q)
      SEQ_IDLE: begin
        if (|(act_q & ~eff_c)) begin
          tgt_d   = eff_c;
          state_d = SEQ_PWR;
        end
      end

      SEQ_PWR: begin
        act_d = rc_release(act_q, tgt_q, eff_c, RC_PWR_MASK);
        rel_c = act_q & ~act_d;
        if (|(rel_c & RC_RAIL_MASK)) begin
          cnt_d   = PWR_LOAD;
          state_d = SEQ_PWR_WAIT;
        end else begin
          state_d = SEQ_TU_REL;
        end
      end

      SEQ_PWR_WAIT: begin
        if (cnt_done_c) state_d = SEQ_TU_REL;
        else            cnt_d   = cnt_q - CNT_W'(1);
      end

      SEQ_TU_REL: begin
        act_d = rc_release(act_q, tgt_q, eff_c, RC_TU_MASK);
        rel_c = act_q & ~act_d;
        if (|(rel_c & RC_TU_MASK)) begin
          cnt_d   = RST_LOAD;
          state_d = SEQ_TU_WAIT;
        end else begin
          state_d = SEQ_DEM_REL;
        end
      end

      SEQ_TU_WAIT: begin
        if (cnt_done_c) state_d = SEQ_DEM_REL;
        else            cnt_d   = cnt_q - CNT_W'(1);
      end

      SEQ_DEM_REL: begin
        act_d = rc_release(act_q, tgt_q, eff_c, RC_DEM_MASK);
        rel_c = act_q & ~act_d;
        if (|(rel_c & RC_DEM_MASK)) begin
          cnt_d   = RST_LOAD;
          state_d = SEQ_DEM_WAIT;
        end else begin
          state_d = SEQ_GATE;
        end
      end

      SEQ_DEM_WAIT: begin
        if (cnt_done_c) state_d = SEQ_GATE;
        else            cnt_d   = cnt_q - CNT_W'(1);
      end

      SEQ_GATE: begin
        act_d   = rc_release(act_q, tgt_q, eff_c, RC_GATE_MASK);
        state_d = SEQ_IDLE;
      end

      default: begin
        state_d = SEQ_IDLE;
      end
    endcase

    // A new disable during a sequence cancels all remaining enable stages
    if ((state_q != SEQ_IDLE) && rising_c) begin
      state_d = SEQ_IDLE;
      act_d   = act_q | eff_c;
    end
  end

  always_comb begin
    busy_d = (state_d != SEQ_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      act_q   <= {RC_W{1'b1}};
      tgt_q   <= {RC_W{1'b1}};
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign act_ctrl = act_q;
  assign busy     = busy_q;
  assign oc_fault = fault_w;

endmodule

// File: doc/fe_power_sequencer.md
# fe_power_sequencer

Timed power/reset sequencer for the front-end. It sits between the host-written `reset_ctrl` register in `joker_control` and the board pins (`SW_nEN`, `FE_*_nRST`, `TU_IIC0_EN`), and replaces direct assignment of those pins. Disables are applied immediately; enables are staged in a fixed order with settle delays. Suspend and sticky overcurrent faults force the affected rails off.

## Interface
- `PWR_SETTLE_CYC`, default 600000: rail settle wait, 10 ms at 60 MHz.
- `RST_HOLD_CYC`, default 6000: wait after each reset-release stage, 100 us.
- `OC_FILTER_CYC`, default 60: consecutive low samples needed to latch an overcurrent fault, 1 us.
- `clk`  in  1  `usb_ulpi_clk` domain.
- `reset`  in  1  asynchronous, active-high.
- `req_ctrl`  in  8  requested state, `reset_ctrl` bit map; '1' = disabled/in reset.
  - 7: tuner I2C gate.
  - 6: CI power.
  - 5: antenna 5V.
  - 4: spare.
  - 3: DTMB demod.
  - 2: ATSC demod.
  - 1: tuner.
  - 0: DVB demod.
- `suspend`  in  1  forces all bits to '1'.
- `ci_overcurrent_n`  in  1  asynchronous, active-low.
- `tps_overcurrent_n`  in  1  asynchronous, active-low.
- `fault_clr`  in  1  single-cycle pulse that clears faults.
- `act_ctrl`  out  8  applied state, same bit map; the top derives pins from it.
- `busy`  out  1  high while an enable sequence is in progress.
- `oc_fault`  out  2  sticky faults: [0] CI, [1] antenna.

## Operation
- Effective target `eff`:
  - `eff = suspend ? 8'hFF : req_ctrl`.
  - `oc_fault[0]` forces `eff[6]=1`.
  - `oc_fault[1]` forces `eff[5]=1`.
- Disable path, active in every state: `act_ctrl <= act_ctrl | eff`.
  - If any bit rises while state is not IDLE, abort to IDLE in the same edge.
- FSM states: IDLE, PWR, PWR_WAIT, TU_REL, TU_WAIT, DEM_REL, DEM_WAIT, GATE.
- IDLE: if `(act_ctrl & ~eff) != 0`, latch `tgt <= eff` and go to PWR.
- PWR: clear `act[6:5]` and `act[4]` per `tgt`.
  - If `act[6:5]` changed, load `cnt = PWR_SETTLE_CYC-1` and go to PWR_WAIT.
  - Otherwise go to TU_REL.
- TU_REL: clear `act[1]` per `tgt`.
  - If it changed, load `cnt = RST_HOLD_CYC-1` and go to TU_WAIT.
  - Otherwise go to DEM_REL.
- DEM_REL: clear `act[3]`, `act[2]`, `act[0]` per `tgt`.
  - If any changed, load `cnt = RST_HOLD_CYC-1` and go to DEM_WAIT.
  - Otherwise go to GATE.
- GATE: clear `act[7]` per `tgt`, then go to IDLE.
- WAIT states: decrement `cnt`; leave when `cnt==0`. The next stage therefore applies exactly N+1 cycles after the previous stage's edge.
- Enable requests arriving mid-sequence are ignored until IDLE, then re-evaluated.
- Overcurrent handling, per input:
  - 2-flop synchronizer.
  - Counter increments while the synced input is low AND the rail is on (`act[6]`, resp. `act[5]`, ==0); it clears otherwise.
  - Reaching `OC_FILTER_CYC` sets the fault; the counter saturates.
- `fault_clr` clears a fault only if the synced input is high that cycle; otherwise it is ignored.
- Reset values: `act_ctrl=8'hFF`, `busy=0`, `oc_fault=2'b00`, state IDLE, counters 0, synchronizers 1.

## Timing
- All outputs are registered.
- Disable latency: `eff` bit set at edge k is visible on `act_ctrl` after edge k+1.
- Enable from IDLE: PWR applies 2 edges after the `eff` change (IDLE detect, PWR apply).
- `busy` is high from the edge entering PWR to the edge entering IDLE.
- Overcurrent: fault is set `2+OC_FILTER_CYC` edges after the pin goes low; the rail bit is forced to 1 one edge later.
- Simultaneous `fault_clr` with a qualifying overcurrent sample: set wins.
- Reset asserted mid-sequence: immediate return to reset values; no partial enables persist.
- Counter width: `$clog2(max(PWR_SETTLE_CYC,RST_HOLD_CYC))`.
- `OC_FILTER_CYC>=1`, `PWR_SETTLE_CYC>=1`, `RST_HOLD_CYC>=1`. A value of 1 means a single-cycle wait.

## Structure
- Shared package `joker_pkg`:
  - bit-index localparams: `RC_GATE=7`, `RC_CIPWR=6`, `RC_ANT=5`, `RC_SPARE=4`, `RC_DTMB=3`, `RC_ATSC=2`, `RC_TU=1`, `RC_DVB=0`.
  - group masks: `RC_PWR_MASK=8'h70`, `RC_DEM_MASK=8'h0D`.
  - sequencer state enum.
- Sub-module `oc_filter`: synchronizer, filter counter, sticky flag and clear qualification. Parameter `OC_FILTER_CYC`; ports `clk`, `reset`, `oc_n`, `rail_on`, `clr`, `fault`. Instantiated twice.

## Test plan
All scenarios run with PWR_SETTLE_CYC=100, RST_HOLD_CYC=20, OC_FILTER_CYC=4.
- Out of reset, `req_ctrl=8'hFF` → `act_ctrl=8'hFF`, `busy=0`, `oc_fault=0`.
- `req_ctrl` 8'hFF→8'h00 at edge 0:
  - `act_ctrl=8'h8F` after edge 2.
  - `8'h8D` after edge 103.
  - `8'h80` after edge 124.
  - `8'h00` after edge 145.
  - `busy` falls at edge 145.
- From `8'h00`, `suspend=1` → `act_ctrl=8'hFF` after one edge. During a PWR_WAIT, setting `req_ctrl[6]=1` gives `act[6]=1` after the next edge and state IDLE.
- Rails on, `ci_overcurrent_n` low for 6 cycles → `oc_fault[0]=1` after edge 6, then `act[6]=1`.
  - `fault_clr` while the pin is low → fault stays set.
  - Pin high for 3 cycles, then `fault_clr` → fault clears and the enable sequence restarts.
- `ci_overcurrent_n` low for 3 cycles → no fault.
  - Rail off (`act[6]=1`) with pin low for 10 cycles → no fault.
- Async `reset` pulse at cycle 50 of PWR_WAIT → `act_ctrl=8'hFF` immediately, `busy=0`; after release the full sequence reruns from PWR.
